// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the rv32i core.
// Walks one instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath selects and write strobes, traps on unknown opcodes and
// counts retired instructions.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_we,
   output logic [2:0]  imm_sel,
   output logic [1:0]  alu_a_sel,
   output logic        alu_b_sel,
   output logic        alu_op,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        illegal,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_LOAD, C_STORE, C_BRANCH, C_OPIMM, C_OP,
      C_LUI, C_AUIPC, C_JAL, C_JALR
   } cls_t;

   state_t state;
   state_t state_next;
   cls_t   cls_q;
   cls_t   cls;
   logic   taken_q;

   function automatic cls_t classify(input logic [6:0] op);
      cls_t c;
      case (op)
         7'b0000011: c = C_LOAD;
         7'b0100011: c = C_STORE;
         7'b1100011: c = C_BRANCH;
         7'b0010011: c = C_OPIMM;
         7'b0110011: c = C_OP;
         7'b0110111: c = C_LUI;
         7'b0010111: c = C_AUIPC;
         7'b1101111: c = C_JAL;
         7'b1100111: c = C_JALR;
         default:    c = C_NONE;
      endcase
      return c;
   endfunction

   // The IR is already valid in DECODE, so decode it directly there;
   // later states use the class captured at the end of DECODE.
   assign cls = (state == S_DECODE) ? classify(opcode) : cls_q;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_next;
   end

   // Instruction class, branch outcome and retired-instruction counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cls_q   <= C_NONE;
         taken_q <= 1'b0;
         instret <= 32'd0;
      end else begin
         if (state == S_DECODE) cls_q   <= classify(opcode);
         if (state == S_EXEC)   taken_q <= branch_taken;
         if (state == S_WB)     instret <= instret + 32'd1;
      end
   end

   // Next-state sequencing; mem_ready only matters where mem_req is high.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (mem_ready) state_next = S_DECODE;
         S_DECODE: state_next = (cls == C_NONE) ? S_TRAP : S_EXEC;
         S_EXEC:   state_next = (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
         S_MEM:    if (mem_ready) state_next = S_WB;
         S_WB:     state_next = S_FETCH;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_FETCH;
      endcase
   end

   // Datapath controls; everything is forced low while reset is asserted
   // so a mid-instruction reset kills requests and strobes at once.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      imm_sel   = 3'd0;
      alu_a_sel = 2'd0;
      alu_b_sel = 1'b0;
      alu_op    = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      reg_we    = 1'b0;
      wb_sel    = 2'd0;
      illegal   = 1'b0;
      if (rst) begin
         if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
            case (cls)
               C_STORE:          imm_sel = 3'd1;
               C_BRANCH:         imm_sel = 3'd2;
               C_LUI, C_AUIPC:   imm_sel = 3'd3;
               C_JAL:            imm_sel = 3'd4;
               default:          imm_sel = 3'd0;
            endcase
         end
         case (state)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
            end
            S_EXEC: begin
               case (cls)
                  C_LOAD, C_STORE, C_JALR: alu_b_sel = 1'b1;
                  C_OPIMM: begin
                     alu_b_sel = 1'b1;
                     alu_op    = 1'b1;
                  end
                  C_OP: alu_op = 1'b1;
                  C_BRANCH, C_JAL, C_AUIPC: begin
                     alu_a_sel = 2'd1;
                     alu_b_sel = 1'b1;
                  end
                  C_LUI: begin
                     alu_a_sel = 2'd2;
                     alu_b_sel = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = (cls == C_STORE);
            end
            S_WB: begin
               pc_we  = 1'b1;
               reg_we = (cls != C_STORE) && (cls != C_BRANCH);
               if (cls == C_JAL || (cls == C_BRANCH && taken_q)) pc_src = 2'd1;
               else if (cls == C_JALR)                           pc_src = 2'd2;
               if (cls == C_LOAD)                     wb_sel = 2'd1;
               else if (cls == C_JAL || cls == C_JALR) wb_sel = 2'd2;
            end
            S_TRAP: illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized checks of multicycle_ctrl
// against an instruction-level reference model.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        branch_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, addr_sel, ir_we;
   logic [2:0]  imm_sel;
   logic [1:0]  alu_a_sel;
   logic        alu_b_sel, alu_op, pc_we;
   logic [1:0]  pc_src;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic [31:0] instret;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] model_cnt = 32'd0;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_we(ir_we), .imm_sel(imm_sel),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
      .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   logic [17:0] obs;
   assign obs = {mem_req, mem_we, addr_sel, ir_we, imm_sel, alu_a_sel, alu_b_sel,
                 alu_op, pc_we, pc_src, reg_we, wb_sel, illegal};

   // Per-opcode behaviour of an instruction as seen by the datapath.
   typedef struct packed {
      logic       legal;
      logic       mem;
      logic       store;
      logic [2:0] imm;
      logic [1:0] a;
      logic       b;
      logic       op;
      logic       rw;
      logic [1:0] wb;
      logic [1:0] pcs_t;
      logic [1:0] pcs_n;
   } props_t;

   function automatic props_t props(input logic [6:0] o);
      props_t p;
      p = '0;
      p.legal = 1'b1;
      case (o)
         7'b0000011: begin p.mem = 1; p.b = 1; p.rw = 1; p.wb = 2'd1; end
         7'b0100011: begin p.mem = 1; p.store = 1; p.imm = 3'd1; p.b = 1; end
         7'b1100011: begin p.imm = 3'd2; p.a = 2'd1; p.b = 1; p.pcs_t = 2'd1; end
         7'b0010011: begin p.b = 1; p.op = 1; p.rw = 1; end
         7'b0110011: begin p.op = 1; p.rw = 1; end
         7'b0110111: begin p.imm = 3'd3; p.a = 2'd2; p.b = 1; p.rw = 1; end
         7'b0010111: begin p.imm = 3'd3; p.a = 2'd1; p.b = 1; p.rw = 1; end
         7'b1101111: begin p.imm = 3'd4; p.a = 2'd1; p.b = 1; p.rw = 1; p.wb = 2'd2;
                           p.pcs_t = 2'd1; p.pcs_n = 2'd1; end
         7'b1100111: begin p.b = 1; p.rw = 1; p.wb = 2'd2; p.pcs_t = 2'd2; p.pcs_n = 2'd2; end
         default:    p.legal = 1'b0;
      endcase
      return p;
   endfunction

   function automatic logic [17:0] mk(input logic mreq, input logic mwe, input logic asel,
                                      input logic irwe, input logic [2:0] imm,
                                      input logic [1:0] a, input logic b, input logic op,
                                      input logic pcwe, input logic [1:0] pcs,
                                      input logic rw, input logic [1:0] wb, input logic ill);
      return {mreq, mwe, asel, irwe, imm, a, b, op, pcwe, pcs, rw, wb, ill};
   endfunction

   task automatic check_vec(input string tag, input logic [17:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: outputs got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input logic [31:0] exp);
      n_tests++;
      assert (instret === exp) else begin
         n_fail++;
         $error("FAIL %s: instret got %0d expected %0d", tag, instret, exp);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #2;
      model_cnt = 32'd0;
      check_vec("reset_outputs", 18'd0);
      check_cnt("reset_instret", 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Runs one instruction cycle by cycle; fw/mw are wait cycles on the
   // fetch and data requests. abort_mem asserts reset in the first MEM cycle.
   task automatic run_instr(input logic [6:0] opc, input logic tk, input int fw,
                            input int mw, input bit abort_mem);
      props_t p;
      p = props(opc);
      opcode = opc;
      for (int i = 0; i <= fw; i++) begin
         mem_ready = (i == fw);
         branch_taken = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_vec("fetch", mk(1, 0, 0, mem_ready, 3'd0, 2'd0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
         @(posedge clk); #1;
      end
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_vec("decode", mk(0, 0, 0, 0, p.imm, 2'd0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
      @(posedge clk); #1;
      if (!p.legal) return;
      mem_ready = 1'($urandom_range(0, 1));
      branch_taken = tk;
      @(negedge clk);
      check_vec("exec", mk(0, 0, 0, 0, p.imm, p.a, p.b, p.op, 0, 2'd0, 0, 2'd0, 0));
      @(posedge clk); #1;
      if (p.mem) begin
         for (int i = 0; i <= mw; i++) begin
            mem_ready = (i == mw) && !abort_mem;
            branch_taken = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_vec("mem", mk(1, p.store, 1, 0, p.imm, 2'd0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
            if (abort_mem) begin
               #2 rst = 1'b0;
               #1;
               model_cnt = 32'd0;
               check_vec("mid_mem_reset", 18'd0);
               check_cnt("mid_mem_reset_instret", 32'd0);
               repeat (2) @(posedge clk);
               #1 rst = 1'b1;
               return;
            end
            @(posedge clk); #1;
         end
      end
      mem_ready = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_vec("wb", mk(0, 0, 0, 0, p.imm, 2'd0, 0, 0, 1, tk ? p.pcs_t : p.pcs_n,
                         p.rw, p.wb, 0));
      @(posedge clk); #1;
      model_cnt = model_cnt + 32'd1;
      check_cnt("instret", model_cnt);
   endtask

   logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                                 7'b0110011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b1100111};

   initial begin
      rst = 1'b0;
      opcode = 7'd0;
      branch_taken = 1'b0;
      mem_ready = 1'b0;
      #3;
      apply_reset();

      run_instr(7'b0010011, 1'b0, 0, 0, 0);   // ADDI
      run_instr(7'b0000011, 1'b0, 0, 2, 0);   // LOAD, 2 wait cycles in MEM
      run_instr(7'b0100011, 1'b0, 0, 0, 0);   // STORE
      run_instr(7'b1100011, 1'b1, 0, 0, 0);   // BRANCH taken
      run_instr(7'b1100011, 1'b0, 0, 0, 0);   // BRANCH not taken
      run_instr(7'b1100111, 1'b0, 0, 0, 0);   // JALR
      run_instr(7'b1101111, 1'b0, 1, 0, 0);   // JAL, fetch wait

      for (int k = 0; k < 40; k++) begin
         run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
      end

      run_instr(7'b0000000, 1'b0, 0, 0, 0);   // illegal opcode
      for (int k = 0; k < 12; k++) begin
         mem_ready = 1'($urandom_range(0, 1));
         branch_taken = 1'($urandom_range(0, 1));
         @(negedge clk);
         check_vec("trap", mk(0, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 2'd0, 0, 2'd0, 1));
         @(posedge clk); #1;
      end
      check_cnt("trap_instret", model_cnt);

      apply_reset();
      run_instr(7'b0000011, 1'b0, 0, 1, 1);   // LOAD interrupted by reset in MEM
      run_instr(7'b0010011, 1'b0, 0, 0, 0);   // resumes cleanly from FETCH

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
